// File: rtl/collector_port_arbiter.sv
// Round-robin arbiter sharing one packet Collector among numPorts local-port requesters.
// Latches the winning packet, holds it toward the Collector, and returns a one-cycle grant upstream.
module collector_port_arbiter #(
    parameter int numPorts      = 4,
    parameter int portBits      = 2,
    parameter int dataWidth     = 32,
    parameter int timeoutCycles = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [numPorts*dataWidth-1:0] PacketIn,
    input  logic [numPorts-1:0]           ReqUpStr,
    output logic [numPorts-1:0]           GntUpStr,
    output logic [numPorts-1:0]           UpStrFull,
    output logic [dataWidth-1:0]          PacketOut,
    output logic                          ReqDnStr,
    input  logic                          GntDnStr,
    input  logic                          DnStrFull,
    output logic [portBits-1:0]           CurPort,
    output logic [15:0]                   ServedCount,
    output logic                          TimeoutErr
);

    localparam int CntW = $clog2(timeoutCycles) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [portBits-1:0]    sel_q, sel_d;
    logic [portBits-1:0]    last_q, last_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [dataWidth-1:0]   packet_q, packet_d;
    logic                   req_dn_q, req_dn_d;
    logic [numPorts-1:0]    gnt_up_q, gnt_up_d;
    logic [numPorts-1:0]    up_full_q, up_full_d;
    logic [15:0]            served_q, served_d;
    logic                   timeout_q, timeout_d;

    logic                   win_found;
    logic [portBits-1:0]    win_idx;
    logic [portBits-1:0]    scan_idx;

    // Scan from the port after the last one served, wrapping, so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= numPorts; k++) begin
            scan_idx = portBits'((int'(last_q) + k) % numPorts);
            if (!win_found && ReqUpStr[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        packet_d  = packet_q;
        req_dn_d  = req_dn_q;
        gnt_up_d  = '0;
        served_d  = served_q;
        timeout_d = timeout_q;
        up_full_d = '0;

        case (state_q)
            IDLE: begin
                if (!DnStrFull && win_found) begin
                    sel_d    = win_idx;
                    packet_d = PacketIn[int'(win_idx)*dataWidth +: dataWidth];
                    req_dn_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (GntDnStr) begin
                    req_dn_d         = 1'b0;
                    gnt_up_d[sel_q]  = 1'b1;
                    last_d           = sel_q;
                    served_d         = served_q + 16'd1;
                    state_d          = RELEASE;
                end else if (cnt_q >= CntW'(timeoutCycles - 1)) begin
                    // Abort: the port forfeits its turn and gets no grant.
                    req_dn_d  = 1'b0;
                    timeout_d = 1'b1;
                    last_d    = sel_q;
                    state_d   = IDLE;
                end else if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < numPorts; i++) begin
            up_full_d[i] = DnStrFull | ((state_d != IDLE) && (sel_d != portBits'(i)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= portBits'(numPorts - 1);
            cnt_q     <= '0;
            packet_q  <= '0;
            req_dn_q  <= 1'b0;
            gnt_up_q  <= '0;
            up_full_q <= '0;
            served_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            packet_q  <= packet_d;
            req_dn_q  <= req_dn_d;
            gnt_up_q  <= gnt_up_d;
            up_full_q <= up_full_d;
            served_q  <= served_d;
            timeout_q <= timeout_d;
        end
    end

    assign GntUpStr    = gnt_up_q;
    assign UpStrFull   = up_full_q;
    assign PacketOut   = packet_q;
    assign ReqDnStr    = req_dn_q;
    assign CurPort     = sel_q;
    assign ServedCount = served_q;
    assign TimeoutErr  = timeout_q;

endmodule

// File: tb/tb_collector_port_arbiter.sv
// Directed bench for collector_port_arbiter with a scoreboard of expected grants and a one-cycle Collector.
module tb_collector_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    logic              clk;
    logic              reset;
    logic [NP*DW-1:0]  PacketIn;
    logic [NP-1:0]     ReqUpStr;
    logic [NP-1:0]     GntUpStr;
    logic [NP-1:0]     UpStrFull;
    logic [DW-1:0]     PacketOut;
    logic              ReqDnStr;
    logic              GntDnStr;
    logic              DnStrFull;
    logic [1:0]        CurPort;
    logic [15:0]       ServedCount;
    logic              TimeoutErr;

    collector_port_arbiter #(
        .numPorts(NP), .portBits(2), .dataWidth(DW), .timeoutCycles(8)
    ) dut (
        .clk(clk), .reset(reset), .PacketIn(PacketIn), .ReqUpStr(ReqUpStr),
        .GntUpStr(GntUpStr), .UpStrFull(UpStrFull), .PacketOut(PacketOut),
        .ReqDnStr(ReqDnStr), .GntDnStr(GntDnStr), .DnStrFull(DnStrFull),
        .CurPort(CurPort), .ServedCount(ServedCount), .TimeoutErr(TimeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] pkt;
    } exp_t;

    exp_t             exp_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [NP*DW-1:0] base_pkts;

    function automatic logic [31:0] pkt_of(input int p);
        return 32'hA5A50001 + (p << 8);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p);
        exp_t e;
        e.port = p;
        e.pkt  = pkt_of(p);
        exp_q.push_back(e);
    endtask

    // Wait for the downstream request, compare against the scoreboard, then act as a one-cycle Collector.
    task automatic serve(input bit reassert, output int waited);
        exp_t e;
        int   n;
        n = 0;
        while (!ReqDnStr && n < 20) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        check("req_dn_seen", 64'(ReqDnStr), 64'd1);
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("cur_port", 64'(CurPort), 64'(e.port));
        check("pkt_out", 64'(PacketOut), 64'(e.pkt));
        check("up_full_busy", 64'(UpStrFull), 64'(4'hF ^ (4'h1 << e.port)));
        PacketIn = ~base_pkts;
        @(negedge clk);
        GntDnStr = 1'b1;
        check("pkt_hold", 64'(PacketOut), 64'(e.pkt));
        @(negedge clk);
        GntDnStr = 1'b0;
        PacketIn = base_pkts;
        check("gnt_up", 64'(GntUpStr), 64'(4'h1 << e.port));
        check("req_dn_drop", 64'(ReqDnStr), 64'd0);
        ReqUpStr[e.port] = 1'b0;
        @(negedge clk);
        check("gnt_pulse", 64'(GntUpStr), 64'd0);
        if (reassert) ReqUpStr[e.port] = 1'b1;
    endtask

    initial begin
        int w;
        int n_hi;
        logic [NP-1:0] gnt_or;

        for (int i = 0; i < NP; i++) base_pkts[i*DW +: DW] = pkt_of(i);
        PacketIn  = base_pkts;
        ReqUpStr  = '0;
        GntDnStr  = 1'b0;
        DnStrFull = 1'b0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #2;
        check("rst_gnt", 64'(GntUpStr), 64'd0);
        check("rst_full", 64'(UpStrFull), 64'd0);
        check("rst_pkt", 64'(PacketOut), 64'd0);
        check("rst_req_dn", 64'(ReqDnStr), 64'd0);
        check("rst_cur", 64'(CurPort), 64'd0);
        check("rst_served", 64'(ServedCount), 64'd0);
        check("rst_tmo", 64'(TimeoutErr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single request
        @(negedge clk);
        ReqUpStr = 4'b0001;
        push(0);
        serve(1'b0, w);
        check("single_latency", 64'(w), 64'd1);
        check("single_served", 64'(ServedCount), 64'd1);
        check("single_cur", 64'(CurPort), 64'd0);

        // Round-robin fairness from a fresh priority
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ReqUpStr = 4'b1111;
        for (int t = 0; t < 8; t++) push(t % 4);
        for (int t = 0; t < 8; t++) serve(1'b1, w);
        ReqUpStr = '0;
        check("rr_served", 64'(ServedCount), 64'd8);

        // Skip and wrap: make port 2 the last served, then ports 0/1 request
        @(negedge clk);
        ReqUpStr = 4'b0100;
        push(2);
        serve(1'b0, w);
        ReqUpStr = 4'b0011;
        push(0);
        push(1);
        serve(1'b0, w);
        serve(1'b0, w);
        check("wrap_served", 64'(ServedCount), 64'd11);

        // Back-pressure
        @(negedge clk);
        DnStrFull = 1'b1;
        ReqUpStr  = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_req_dn", 64'(ReqDnStr), 64'd0);
            check("bp_full", 64'(UpStrFull), 64'hF);
        end
        DnStrFull = 1'b0;
        push(2);
        serve(1'b0, w);
        check("bp_served", 64'(ServedCount), 64'd12);

        // Timeout: Collector never grants
        @(negedge clk);
        ReqUpStr = 4'b0010;
        w = 0;
        while (!ReqDnStr && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("tmo_req_dn_seen", 64'(ReqDnStr), 64'd1);
        n_hi   = 0;
        gnt_or = '0;
        while (ReqDnStr && n_hi < 40) begin
            n_hi++;
            gnt_or |= GntUpStr;
            @(negedge clk);
        end
        ReqUpStr = '0;
        check("tmo_wait_len", 64'(n_hi), 64'd8);
        check("tmo_no_gnt", 64'(gnt_or), 64'd0);
        check("tmo_flag", 64'(TimeoutErr), 64'd1);
        check("tmo_served", 64'(ServedCount), 64'd12);
        repeat (3) @(negedge clk);
        check("tmo_sticky", 64'(TimeoutErr), 64'd1);
        check("tmo_idle_req_dn", 64'(ReqDnStr), 64'd0);
        ReqUpStr = 4'b0100;
        push(2);
        serve(1'b0, w);
        check("tmo_after_served", 64'(ServedCount), 64'd13);
        check("tmo_after_sticky", 64'(TimeoutErr), 64'd1);

        // Mid-transfer reset
        @(negedge clk);
        ReqUpStr = 4'b0100;
        w = 0;
        while (!ReqDnStr && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("mrst_req_dn_seen", 64'(ReqDnStr), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mrst_req_dn", 64'(ReqDnStr), 64'd0);
        check("mrst_gnt", 64'(GntUpStr), 64'd0);
        check("mrst_served", 64'(ServedCount), 64'd0);
        check("mrst_tmo", 64'(TimeoutErr), 64'd0);
        ReqUpStr = '0;
        @(negedge clk);
        reset    = 1'b1;
        ReqUpStr = 4'b1111;
        push(0);
        serve(1'b0, w);
        ReqUpStr = '0;
        check("mrst_first_served", 64'(ServedCount), 64'd1);
        check("mrst_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
